// File: rtl/gen_fir_pkg.sv
// Shared types and helpers for the waveform generator + serial-MAC FIR.
// FSM encoding, waveform select codes, clog2 and accumulator sizing.
package gen_fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_OUT
  } fsm_e;

  localparam logic [1:0] SEL_SAW  = 2'd0;
  localparam logic [1:0] SEL_TRI  = 2'd1;
  localparam logic [1:0] SEL_SQR  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // One growth bit per doubling of taps keeps the sum exact.
  function automatic int acc_width(
    input int nb_data,
    input int nb_coef,
    input int n_taps
  );
    return nb_data + nb_coef + clog2(n_taps);
  endfunction

endpackage

// File: rtl/gen_fir_mac_wave_gen.sv
// Sample-rate divider, phase accumulator and waveform mapping.
// Ports: i_clock/i_reset/i_enable, i_sel, i_step -> o_tick, o_sample.
module wave_gen
  import gen_fir_pkg::*;
#(
  parameter int NB_SEL      = 2,
  parameter int NB_PHASE    = 16,
  parameter int NB_DATA_GEN = 8,
  parameter int SAMPLE_DIV  = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [NB_SEL-1:0]             i_sel,
  input  logic [NB_PHASE-1:0]           i_step,
  output logic                          o_tick,
  output logic signed [NB_DATA_GEN-1:0] o_sample
);

  localparam int N      = NB_DATA_GEN;
  localparam int NB_DIV = clog2(SAMPLE_DIV);
  localparam logic [NB_DIV-1:0] CNT_MAX =
    NB_DIV'(SAMPLE_DIV - 1);
  localparam logic [N-1:0] SQ_POS =
    {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SQ_NEG =
    {1'b1, {(N-2){1'b0}}, 1'b1};

  logic [NB_DIV-1:0]   cnt_q, cnt_d;
  logic [NB_PHASE-1:0] phase_q, phase_d;
  logic [N-1:0]        smp_q, smp_d;
  logic [N-1:0]        p;
  logic                m;
  logic [N-2:0]        t;
  logic [N-1:0]        wave;
  logic                tick;

  assign tick = i_enable && (cnt_q == CNT_MAX);
  assign p    = phase_q[NB_PHASE-1 -: N];
  assign m    = p[N-1];
  assign t    = m ? ~p[N-2:0] : p[N-2:0];

  always_comb begin
    wave = '0;
    unique case (1'b1)
      (i_sel == NB_SEL'(SEL_SAW)):
        wave = {~m, p[N-2:0]};
      (i_sel == NB_SEL'(SEL_TRI)):
        wave = {~t[N-2], t[N-3:0], 1'b0};
      (i_sel == NB_SEL'(SEL_SQR)):
        wave = m ? SQ_NEG : SQ_POS;
      (i_sel == NB_SEL'(SEL_ZERO)):
        wave = '0;
      default:
        wave = '0;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    smp_d   = smp_q;
    if (i_enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      phase_d = phase_q + i_step;
      smp_d   = wave;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      cnt_q   <= '0;
      phase_q <= '0;
      smp_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      smp_q   <= smp_d;
    end
  end

  assign o_tick   = tick;
  assign o_sample = smp_q;

endmodule

// File: rtl/gen_fir_mac.sv
// Waveform source feeding a programmable FIR with one serial MAC.
// Ports: clock/reset/enable, sel/step, coef write port, o_signal/o_valid.
module gen_fir_mac
  import gen_fir_pkg::*;
#(
  parameter int NB_SEL      = 2,
  parameter int NB_PHASE    = 16,
  parameter int NB_DATA_GEN = 8,
  parameter int NB_COEF     = 8,
  parameter int NB_DATA_OUT = 8,
  parameter int N_TAPS      = 8,
  parameter int SAMPLE_DIV  = 16,
  parameter int NB_ADDR     = clog2(N_TAPS)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic [NB_SEL-1:0]      i_sel,
  input  logic [NB_PHASE-1:0]    i_step,
  input  logic                   i_coef_wr,
  input  logic [NB_ADDR-1:0]     i_coef_addr,
  input  logic [NB_COEF-1:0]     i_coef_data,
  output logic                   o_coef_ready,
  output logic [NB_DATA_OUT-1:0] o_signal,
  output logic                   o_valid
);

  localparam int NB_ACC  =
    acc_width(NB_DATA_GEN, NB_COEF, N_TAPS);
  localparam int NB_PROD = NB_DATA_GEN + NB_COEF;

  localparam logic signed [NB_ACC-1:0] RND =
    NB_ACC'(2 ** (NB_COEF - 2));
  localparam logic signed [NB_ACC-1:0] OMAX =
    NB_ACC'(2 ** (NB_DATA_OUT - 1) - 1);
  localparam logic signed [NB_ACC-1:0] OMIN =
    NB_ACC'(-(2 ** (NB_DATA_OUT - 1)));
  localparam logic [NB_COEF-1:0] COEF_HALF =
    NB_COEF'(2 ** (NB_COEF - 2));
  localparam logic [NB_ADDR-1:0] K_LAST =
    NB_ADDR'(N_TAPS - 1);

  if (SAMPLE_DIV < N_TAPS + 3) begin : g_div_chk
    $error("SAMPLE_DIV must be >= N_TAPS+3");
  end

  fsm_e                          state_q;
  logic [NB_ADDR-1:0]            k_q;
  logic signed [NB_ACC-1:0]      acc_q;
  logic [NB_DATA_OUT-1:0]        signal_q;
  logic                          valid_q;
  logic signed [NB_DATA_GEN-1:0] x_q    [N_TAPS];
  logic signed [NB_COEF-1:0]     coef_q [N_TAPS];

  logic                          tick;
  logic signed [NB_DATA_GEN-1:0] sample;
  logic signed [NB_PROD-1:0]     prod;
  logic signed [NB_ACC-1:0]      acc_d;
  logic signed [NB_ACC-1:0]      rnd_d;
  logic signed [NB_ACC-1:0]      shr_d;
  logic [NB_DATA_OUT-1:0]        sat_d;
  logic                          ready;
  logic                          addr_ok;
  logic                          coef_we;

  wave_gen #(
    .NB_SEL     (NB_SEL),
    .NB_PHASE   (NB_PHASE),
    .NB_DATA_GEN(NB_DATA_GEN),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_wave (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .i_sel   (i_sel),
    .i_step  (i_step),
    .o_tick  (tick),
    .o_sample(sample)
  );

  assign ready   = (state_q == ST_IDLE) && !tick;
  assign addr_ok = (int'(i_coef_addr) < N_TAPS);
  assign coef_we = i_coef_wr && ready && addr_ok;

  assign prod  = x_q[k_q] * coef_q[k_q];
  assign acc_d = acc_q + NB_ACC'(prod);
  assign rnd_d = acc_d + RND;
  assign shr_d = rnd_d >>> (NB_COEF - 1);

  always_comb begin
    sat_d = shr_d[NB_DATA_OUT-1:0];
    if (shr_d > OMAX) sat_d = OMAX[NB_DATA_OUT-1:0];
    if (shr_d < OMIN) sat_d = OMIN[NB_DATA_OUT-1:0];
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        coef_q[i] <= (i == 0) ? COEF_HALF : '0;
      end
    end else if (coef_we) begin
      coef_q[i_coef_addr] <= i_coef_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      signal_q <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (tick) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          x_q[0] <= sample;
          for (int i = 1; i < N_TAPS; i++) begin
            x_q[i] <= x_q[i-1];
          end
          acc_q   <= '0;
          k_q     <= '0;
          state_q <= ST_MAC;
        end
        ST_MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
          // Last product folds straight into the
          // rounded result so o_valid lands on time.
          if (k_q == K_LAST) begin
            signal_q <= sat_d;
            valid_q  <= 1'b1;
            state_q  <= ST_OUT;
          end
        end
        ST_OUT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_coef_ready = ready;
  assign o_signal     = signal_q;
  assign o_valid      = valid_q;

endmodule
